// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcode constants, FSM state encoding and the
// opcode-to-immediate-format lookup used by fetch, decode and execute.
package instruction_decode_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b10
   } dec_state_e;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,   // register-register, no immediate
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6,   // FENCE: legal, immediate forced to zero
      FMT_BAD  = 3'd7    // unsupported encoding
   } imm_fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Map a 7-bit opcode onto its immediate format; unknown opcodes are FMT_BAD.
   function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
      imm_fmt_e fmt;
      case (op)
         OP_OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
         OP_STORE:                               fmt = FMT_S;
         OP_BRANCH:                              fmt = FMT_B;
         OP_LUI, OP_AUIPC:                       fmt = FMT_U;
         OP_JAL:                                 fmt = FMT_J;
         OP_OP:                                  fmt = FMT_R;
         OP_FENCE:                               fmt = FMT_NONE;
         default:                                fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/instruction_decode_decode_imm.sv
// Combinational immediate generator: sign-extends the immediate of a 32-bit
// instruction according to its opcode format and flags unsupported encodings.
module decode_imm
   import instruction_decode_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic        illegal
);

   imm_fmt_e fmt_s;

   // Select the immediate layout from the opcode and assemble it.
   always_comb begin
      fmt_s   = opcode_fmt(instr[6:0]);
      imm     = 32'd0;
      illegal = 1'b0;
      case (fmt_s)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'd0};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
         FMT_R:   imm = 32'd0;
         FMT_NONE: imm = 32'd0;
         default: begin
            imm     = 32'd0;
            illegal = 1'b1;
         end
      endcase
      // Compressed / non-32-bit encodings are never supported.
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         illegal = illegal;
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: one output register plus one skid register so fetch sees a
// registered stall. Decoded fields are computed on the word being loaded and
// registered, so every output comes straight from a flop.
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int IWIDTH   = 32,
   parameter int PC_WIDTH = 32
)(
   input  logic                d_clk,
   input  logic                d_rst,
   input  logic [IWIDTH-1:0]   d_i_instr,
   input  logic [PC_WIDTH-1:0] d_i_pc,
   input  logic                d_i_ce,
   output logic                d_o_stall,
   input  logic                d_i_stall,
   input  logic                d_i_flush,
   output logic                d_o_flush,
   output logic                d_o_ce,
   output logic [PC_WIDTH-1:0] d_o_pc,
   output logic [6:0]          d_o_opcode,
   output logic [4:0]          d_o_rd_addr,
   output logic [4:0]          d_o_rs1_addr,
   output logic [4:0]          d_o_rs2_addr,
   output logic [2:0]          d_o_funct3,
   output logic [6:0]          d_o_funct7,
   output logic [31:0]         d_o_imm,
   output logic                d_o_illegal
);

   dec_state_e          state_r;
   dec_state_e          next_state_s;
   logic [IWIDTH-1:0]   skid_instr_r;
   logic [PC_WIDTH-1:0] skid_pc_r;
   logic                accept_s;
   logic                load_out_s;
   logic                load_skid_s;
   logic                from_skid_s;
   logic [IWIDTH-1:0]   load_instr_s;
   logic [PC_WIDTH-1:0] load_pc_s;
   logic [31:0]         word_s;
   logic [31:0]         load_imm_s;
   logic                load_illegal_s;

   // d_o_stall is exactly (state==SKID), so it doubles as the registered stall.
   assign accept_s = d_i_ce & ~d_o_stall;

   // Next-state and register-load decisions for the output/skid pair.
   always_comb begin
      next_state_s = state_r;
      load_out_s   = 1'b0;
      load_skid_s  = 1'b0;
      from_skid_s  = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               next_state_s = ST_FULL;
               load_out_s   = 1'b1;
            end else begin
               next_state_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (accept_s && d_i_stall) begin
               next_state_s = ST_SKID;
               load_skid_s  = 1'b1;
            end else if (accept_s) begin
               next_state_s = ST_FULL;
               load_out_s   = 1'b1;
            end else if (!d_i_stall) begin
               next_state_s = ST_EMPTY;
            end else begin
               next_state_s = ST_FULL;
            end
         end
         ST_SKID: begin
            if (!d_i_stall) begin
               next_state_s = ST_FULL;
               load_out_s   = 1'b1;
               from_skid_s  = 1'b1;
            end else begin
               next_state_s = ST_SKID;
            end
         end
         default: next_state_s = ST_EMPTY;
      endcase
   end

   // Word headed for the output register: the skid entry drains first.
   always_comb begin
      if (from_skid_s) begin
         load_instr_s = skid_instr_r;
         load_pc_s    = skid_pc_r;
      end else begin
         load_instr_s = d_i_instr;
         load_pc_s    = d_i_pc;
      end
      word_s = 32'(load_instr_s);
   end

   decode_imm u_decode_imm (
      .instr   (word_s),
      .imm     (load_imm_s),
      .illegal (load_illegal_s)
   );

   // FSM, skid storage and registered decode outputs; reset then flush win.
   always_ff @(posedge d_clk) begin
      if (d_rst) begin
         state_r      <= ST_EMPTY;
         skid_instr_r <= '0;
         skid_pc_r    <= '0;
         d_o_stall    <= 1'b0;
         d_o_flush    <= 1'b0;
         d_o_ce       <= 1'b0;
         d_o_pc       <= '0;
         d_o_opcode   <= 7'd0;
         d_o_rd_addr  <= 5'd0;
         d_o_rs1_addr <= 5'd0;
         d_o_rs2_addr <= 5'd0;
         d_o_funct3   <= 3'd0;
         d_o_funct7   <= 7'd0;
         d_o_imm      <= 32'd0;
         d_o_illegal  <= 1'b0;
      end else if (d_i_flush) begin
         state_r      <= ST_EMPTY;
         skid_instr_r <= '0;
         skid_pc_r    <= '0;
         d_o_stall    <= 1'b0;
         d_o_flush    <= 1'b1;
         d_o_ce       <= 1'b0;
         d_o_illegal  <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         d_o_stall <= (next_state_s == ST_SKID);
         d_o_ce    <= (next_state_s != ST_EMPTY);
         d_o_flush <= 1'b0;
         if (load_skid_s) begin
            skid_instr_r <= d_i_instr;
            skid_pc_r    <= d_i_pc;
         end
         if (load_out_s) begin
            d_o_pc       <= load_pc_s;
            d_o_opcode   <= word_s[6:0];
            d_o_rd_addr  <= word_s[11:7];
            d_o_rs1_addr <= word_s[19:15];
            d_o_rs2_addr <= word_s[24:20];
            d_o_funct3   <= word_s[14:12];
            d_o_funct7   <= word_s[31:25];
            d_o_imm      <= load_imm_s;
            d_o_illegal  <= load_illegal_s;
         end
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

   logic        d_clk = 1'b0;
   logic        d_rst;
   logic [31:0] d_i_instr;
   logic [31:0] d_i_pc;
   logic        d_i_ce;
   logic        d_o_stall;
   logic        d_i_stall;
   logic        d_i_flush;
   logic        d_o_flush;
   logic        d_o_ce;
   logic [31:0] d_o_pc;
   logic [6:0]  d_o_opcode;
   logic [4:0]  d_o_rd_addr;
   logic [4:0]  d_o_rs1_addr;
   logic [4:0]  d_o_rs2_addr;
   logic [2:0]  d_o_funct3;
   logic [6:0]  d_o_funct7;
   logic [31:0] d_o_imm;
   logic        d_o_illegal;

   int vec_cnt = 0;
   int err_cnt = 0;

   instruction_decode #(.IWIDTH(32), .PC_WIDTH(32)) dut (
      .d_clk(d_clk), .d_rst(d_rst),
      .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_ce(d_i_ce),
      .d_o_stall(d_o_stall), .d_i_stall(d_i_stall),
      .d_i_flush(d_i_flush), .d_o_flush(d_o_flush),
      .d_o_ce(d_o_ce), .d_o_pc(d_o_pc), .d_o_opcode(d_o_opcode),
      .d_o_rd_addr(d_o_rd_addr), .d_o_rs1_addr(d_o_rs1_addr),
      .d_o_rs2_addr(d_o_rs2_addr), .d_o_funct3(d_o_funct3),
      .d_o_funct7(d_o_funct7), .d_o_imm(d_o_imm), .d_o_illegal(d_o_illegal)
   );

   always #5 d_clk = ~d_clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge d_clk);
      #1;
   endtask

   // Load w1 into the output register, then w2 into skid under stall.
   task automatic fill_skid(input logic [31:0] w1, input logic [31:0] w2);
      d_i_ce = 1'b1; d_i_stall = 1'b0; d_i_instr = w1; d_i_pc = 32'h200;
      tick();
      d_i_instr = w2; d_i_pc = 32'h204; d_i_stall = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      d_rst = 1'b1; d_i_ce = 1'b1; d_i_instr = 32'h00500093; d_i_pc = 32'h10;
      d_i_stall = 1'b0; d_i_flush = 1'b1;
      tick(); tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_flush, d_o_illegal} !== 4'b0000) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got %b want 0000", {d_o_ce, d_o_stall, d_o_flush, d_o_illegal});
      end
      vec_cnt++;
      if ({d_o_pc, d_o_opcode, d_o_rd_addr, d_o_rs1_addr, d_o_rs2_addr,
           d_o_funct3, d_o_funct7, d_o_imm} !== '0) begin
         err_cnt++;
         $display("FAIL reset_data: pc=%h op=%h imm=%h want all zero", d_o_pc, d_o_opcode, d_o_imm);
      end
      d_rst = 1'b0; d_i_ce = 1'b0; d_i_flush = 1'b0;
      tick();
   endtask

   task automatic test_single_word();
      d_i_ce = 1'b1; d_i_instr = 32'h00500093; d_i_pc = 32'h0;
      tick();
      d_i_ce = 1'b0;
      vec_cnt++;
      if ({d_o_ce, d_o_rd_addr, d_o_rs1_addr, d_o_imm, d_o_opcode, d_o_illegal, d_o_pc}
          !== {1'b1, 5'd1, 5'd0, 32'd5, 7'h13, 1'b0, 32'h0}) begin
         err_cnt++;
         $display("FAIL single_word: ce=%b rd=%0d rs1=%0d imm=%h op=%h ill=%b pc=%h want 1 1 0 5 13 0 0",
                  d_o_ce, d_o_rd_addr, d_o_rs1_addr, d_o_imm, d_o_opcode, d_o_illegal, d_o_pc);
      end
      tick();
      vec_cnt++;
      if (d_o_ce !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_drain: ce=%b want 0", d_o_ce);
      end
   endtask

   task automatic test_back_pressure();
      // w1 rd2 imm1, w2 rd3 imm2, w3 rd4 imm3
      d_i_stall = 1'b0; d_i_ce = 1'b1; d_i_instr = 32'h00100113; d_i_pc = 32'h100;
      tick();
      d_i_instr = 32'h00200193; d_i_pc = 32'h104; d_i_stall = 1'b1;
      tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_rd_addr, d_o_pc} !== {1'b1, 1'b1, 5'd2, 32'h100}) begin
         err_cnt++;
         $display("FAIL bp_skid: ce=%b stall=%b rd=%0d pc=%h want 1 1 2 100", d_o_ce, d_o_stall, d_o_rd_addr, d_o_pc);
      end
      d_i_instr = 32'h00300213; d_i_pc = 32'h108;
      tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm} !== {1'b1, 1'b1, 5'd2, 32'd1}) begin
         err_cnt++;
         $display("FAIL bp_hold: ce=%b stall=%b rd=%0d imm=%h want 1 1 2 1", d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm);
      end
      d_i_stall = 1'b0;
      tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm, d_o_pc} !== {1'b1, 1'b0, 5'd3, 32'd2, 32'h104}) begin
         err_cnt++;
         $display("FAIL bp_second: ce=%b stall=%b rd=%0d imm=%h pc=%h want 1 0 3 2 104",
                  d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm, d_o_pc);
      end
      tick();
      d_i_ce = 1'b0;
      vec_cnt++;
      if ({d_o_ce, d_o_rd_addr, d_o_imm, d_o_pc} !== {1'b1, 5'd4, 32'd3, 32'h108}) begin
         err_cnt++;
         $display("FAIL bp_third: ce=%b rd=%0d imm=%h pc=%h want 1 4 3 108", d_o_ce, d_o_rd_addr, d_o_imm, d_o_pc);
      end
      tick();
      vec_cnt++;
      if (d_o_ce !== 1'b0) begin
         err_cnt++;
         $display("FAIL bp_drain: ce=%b want 0 (duplicate word)", d_o_ce);
      end
   endtask

   task automatic test_immediates();
      logic [31:0] instrs [6];
      logic [31:0] imms   [6];
      logic [6:0]  ops    [6];
      instrs[0] = 32'hFE000EE3; imms[0] = 32'hFFFFFFFC; ops[0] = 7'h63;
      instrs[1] = 32'h0080006F; imms[1] = 32'h00000008; ops[1] = 7'h6F;
      instrs[2] = 32'h123450B7; imms[2] = 32'h12345000; ops[2] = 7'h37;
      instrs[3] = 32'h0020A423; imms[3] = 32'h00000008; ops[3] = 7'h23;
      instrs[4] = 32'hFFF00093; imms[4] = 32'hFFFFFFFF; ops[4] = 7'h13;
      instrs[5] = 32'h402081B3; imms[5] = 32'h00000000; ops[5] = 7'h33;
      d_i_stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d_i_ce = 1'b1; d_i_instr = instrs[i]; d_i_pc = 32'h300 + 32'(i * 4);
         tick();
         vec_cnt++;
         if ({d_o_ce, d_o_imm, d_o_opcode, d_o_illegal, d_o_pc}
             !== {1'b1, imms[i], ops[i], 1'b0, 32'h300 + 32'(i * 4)}) begin
            err_cnt++;
            $display("FAIL imm_%0d: ce=%b imm=%h op=%h ill=%b pc=%h want 1 %h %h 0 %h",
                     i, d_o_ce, d_o_imm, d_o_opcode, d_o_illegal, d_o_pc,
                     imms[i], ops[i], 32'h300 + 32'(i * 4));
         end
      end
      vec_cnt++;
      if ({d_o_funct7, d_o_rs2_addr, d_o_rs1_addr, d_o_funct3, d_o_rd_addr}
          !== {7'h20, 5'd2, 5'd1, 3'd0, 5'd3}) begin
         err_cnt++;
         $display("FAIL rtype_fields: f7=%h rs2=%0d rs1=%0d f3=%0d rd=%0d want 20 2 1 0 3",
                  d_o_funct7, d_o_rs2_addr, d_o_rs1_addr, d_o_funct3, d_o_rd_addr);
      end
      d_i_ce = 1'b0;
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] bad [3];
      bad[0] = 32'h00000000; bad[1] = 32'h00000010; bad[2] = 32'h0000007F;
      d_i_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_i_ce = 1'b1; d_i_instr = bad[i]; d_i_pc = 32'h400;
         tick();
         vec_cnt++;
         if ({d_o_ce, d_o_illegal} !== 2'b11) begin
            err_cnt++;
            $display("FAIL illegal_%0d: ce=%b ill=%b want 1 1", i, d_o_ce, d_o_illegal);
         end
      end
      d_i_ce = 1'b0;
      tick();
   endtask

   task automatic test_flush_skid();
      fill_skid(32'h00100113, 32'h00200193);
      vec_cnt++;
      if (d_o_stall !== 1'b1) begin
         err_cnt++;
         $display("FAIL flush_pre: stall=%b want 1", d_o_stall);
      end
      d_i_flush = 1'b1; d_i_ce = 1'b1; d_i_instr = 32'h00300213; d_i_pc = 32'h208;
      tick();
      d_i_flush = 1'b0; d_i_ce = 1'b0; d_i_stall = 1'b0;
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_flush} !== 3'b001) begin
         err_cnt++;
         $display("FAIL flush_apply: ce=%b stall=%b oflush=%b want 0 0 1", d_o_ce, d_o_stall, d_o_flush);
      end
      tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_flush} !== 3'b000) begin
         err_cnt++;
         $display("FAIL flush_after: ce=%b stall=%b oflush=%b want 0 0 0", d_o_ce, d_o_stall, d_o_flush);
      end
      d_i_ce = 1'b1; d_i_instr = 32'h00500093; d_i_pc = 32'h20;
      tick();
      d_i_ce = 1'b0;
      vec_cnt++;
      if ({d_o_ce, d_o_rd_addr, d_o_imm, d_o_pc} !== {1'b1, 5'd1, 32'd5, 32'h20}) begin
         err_cnt++;
         $display("FAIL flush_restart: ce=%b rd=%0d imm=%h pc=%h want 1 1 5 20", d_o_ce, d_o_rd_addr, d_o_imm, d_o_pc);
      end
      tick();
   endtask

   task automatic test_reset_skid();
      fill_skid(32'h00100113, 32'h00200193);
      d_rst = 1'b1; d_i_ce = 1'b1; d_i_instr = 32'h00300213; d_i_pc = 32'h208;
      tick();
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_flush, d_o_illegal, d_o_pc, d_o_opcode, d_o_rd_addr,
           d_o_rs1_addr, d_o_rs2_addr, d_o_funct3, d_o_funct7, d_o_imm} !== '0) begin
         err_cnt++;
         $display("FAIL rst_skid: ce=%b stall=%b rd=%0d imm=%h pc=%h want all zero",
                  d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm, d_o_pc);
      end
      d_rst = 1'b0; d_i_stall = 1'b0; d_i_instr = 32'h00500093; d_i_pc = 32'h40;
      tick();
      d_i_ce = 1'b0;
      vec_cnt++;
      if ({d_o_ce, d_o_stall, d_o_rd_addr, d_o_rs1_addr, d_o_imm, d_o_opcode, d_o_pc}
          !== {1'b1, 1'b0, 5'd1, 5'd0, 32'd5, 7'h13, 32'h40}) begin
         err_cnt++;
         $display("FAIL rst_first: ce=%b stall=%b rd=%0d imm=%h op=%h pc=%h want 1 0 1 5 13 40",
                  d_o_ce, d_o_stall, d_o_rd_addr, d_o_imm, d_o_opcode, d_o_pc);
      end
      tick();
      vec_cnt++;
      if (d_o_ce !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_drain: ce=%b want 0", d_o_ce);
      end
   endtask

   initial begin
      d_rst = 1'b1; d_i_instr = 32'h0; d_i_pc = 32'h0;
      d_i_ce = 1'b0; d_i_stall = 1'b0; d_i_flush = 1'b0;
      test_reset();
      test_single_word();
      test_back_pressure();
      test_immediates();
      test_illegal();
      test_flush_skid();
      test_reset_skid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter IWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-003 SHALL have one clock and synchronous active-high reset: d_clk  in  1  clock (all state on rising edge); d_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have these ports:
- d_i_instr  in  IWIDTH  instruction from fetch
- d_i_pc  in  PC_WIDTH  PC of d_i_instr
- d_i_ce  in  1  fetch output valid
- d_o_stall  out  1  back-pressure to fetch
- d_i_stall  in  1  back-pressure from execute
- d_i_flush  in  1  pipeline flush from execute
- d_o_flush  out  1  flush propagated downstream
- d_o_ce  out  1  decode output valid
- d_o_pc  out  PC_WIDTH  PC of decoded instruction
- d_o_opcode  out  7  instr[6:0]
- d_o_rd_addr, d_o_rs1_addr, d_o_rs2_addr  out  5 each  register addresses
- d_o_funct3  out  3
- d_o_funct7  out  7
- d_o_imm  out  32  sign-extended immediate
- d_o_illegal  out  1  unsupported encoding

Function
REQ-005 SHALL accept an input word when d_i_ce=1 and d_o_stall=0 in the same cycle.
REQ-006 SHALL hold a one-entry output register and a one-entry skid register, controlled by an FSM with states EMPTY, FULL and SKID.
REQ-007 SHALL drive d_o_stall as a registered signal equal to (state==SKID).
REQ-008 SHALL use these FSM transitions:
- EMPTY + accept -> FULL.
- FULL + accept + !d_i_stall -> FULL, with the output register replaced.
- FULL + accept + d_i_stall -> SKID, with the word stored in the skid register.
- FULL + no accept + !d_i_stall -> EMPTY.
- FULL + no accept + d_i_stall -> FULL, holding.
- SKID + !d_i_stall -> FULL, with skid moved to the output register.
- SKID + d_i_stall -> SKID, holding.
REQ-009 SHALL assert d_o_ce exactly when state is FULL or SKID; all decoded outputs SHALL be stable while d_o_ce=1 and d_i_stall=1.
REQ-010 SHALL have latency of one cycle: a word accepted at edge N appears on the outputs with d_o_ce=1 after edge N.
REQ-011 SHALL give flush priority over all other events: d_i_flush=1 forces the next state to EMPTY, discards both entries, clears d_o_ce, and ignores any simultaneous accept.
REQ-012 SHALL drive d_o_flush as d_i_flush delayed one cycle.
REQ-013 SHALL produce d_o_imm from the stored instruction, sign-extended from bit 31, by format:
- I: opcodes 0010011, 0000011, 1100111, 1110011
- S: 0100011
- B: 1100011 (bit 0 = 0)
- U: 0110111, 0010111 (low 12 bits = 0)
- J: 1101111 (bit 0 = 0)
- R (0110011) and FENCE (0001111): 0
REQ-014 SHALL assert d_o_illegal when instr[1:0]!=2'b11 or the opcode is not listed in REQ-013; an illegal word still flows with d_o_ce=1.
REQ-015 SHALL register the field outputs (rd/rs1/rs2/funct3/funct7) straight from instruction bits, regardless of format.

Reset
REQ-016 SHALL, while d_rst=1, set state to EMPTY and drive d_o_ce, d_o_stall, d_o_flush, d_o_illegal to 0 and all data outputs to 0.
REQ-017 SHALL, when reset is asserted mid-operation, discard both entries, and SHALL accept no words in a cycle with d_rst=1.

Structure
REQ-018 SHALL take the opcode constants and FSM state encoding from a shared package/include used by fetch and execute.
REQ-019 SHALL implement immediate generation as one combinational sub-module, decode_imm.

Verification
REQ-020 SHALL be verified by these directed scenarios:
- Single word: reset, then instr 0x00500093 (addi x1,x0,5) at pc 0x0 with ce=1 -> next cycle d_o_ce=1, rd=1, rs1=0, imm=5, opcode=0x13, illegal=0.
- Back-pressure: stream 3 words with d_i_stall=1 from cycle 2 -> second word in skid, d_o_stall=1, no third accept; release stall -> words emerge in order, none lost or duplicated.
- Immediates: B-type 0xFE000EE3 -> imm=0xFFFFFFFC (-4); J-type 0x0080006F -> imm=8; U-type 0x123450B7 -> imm=0x12345000.
- Flush in SKID, with a simultaneous d_i_ce=1 -> next cycle d_o_ce=0, d_o_stall=0, state EMPTY; d_o_flush=1 one cycle after d_i_flush.
- Illegal: instr 0x00000000 -> d_o_illegal=1, d_o_ce=1.
- Reset mid-stream in SKID -> all outputs 0 the next cycle; first word after reset decodes correctly.
